// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the writeback sources and regfile_wb_arbiter.
// Requester i drives req_valid[i], req_addr[i*ADDR_W +: ADDR_W] and
// req_data[i*DATA_W +: DATA_W], and sees its one-hot grant on req_ready[i].
//   master : the writeback sources (ALU, load unit, CSR unit, ...)
//   slave  : the arbiter
interface regfile_wb_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// NUM_REQ (2..4) writeback requesters, with one registered output stage.
//
// Ports:
//   clk        system clock, all state on posedge
//   rst        synchronous active-high reset (wins over flush and grants)
//   flush      suppresses all grants and freezes the RR pointer
//   req_bus    slave side of the request bus (valid/addr/data in, ready out)
//   WriteEn    register file write enable (registered)
//   WriteAddr  register file write address (registered)
//   WriteData  register file write data (registered)
//   grant_id   requester whose write is on the port (registered)
//
// Optional feature, macro WB_FWD_EN: adds fwd_addr1/fwd_addr2 inputs and
// fwd_hit1/fwd_hit2/fwd_data outputs, a combinational bypass of the write
// currently on the port so the read stage sees it before the regfile updates.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  regfile_wb_arbiter_if.slave req_bus,
`ifdef WB_FWD_EN
  input  logic [ADDR_W-1:0]   fwd_addr1,
  input  logic [ADDR_W-1:0]   fwd_addr2,
  output logic                fwd_hit1,
  output logic                fwd_hit2,
  output logic [DATA_W-1:0]   fwd_data,
`endif
  output logic                WriteEn,
  output logic [ADDR_W-1:0]   WriteAddr,
  output logic [DATA_W-1:0]   WriteData,
  output logic [1:0]          grant_id
);

  logic [1:0]         ptr_q, ptr_d;
  logic               hi_found, lo_found;
  logic [1:0]         hi_idx, lo_idx;
  logic               grant_valid;
  logic [1:0]         grant_idx;
  logic [ADDR_W-1:0]  grant_addr;
  logic [DATA_W-1:0]  grant_data;
  logic               do_write;
  logic [NUM_REQ-1:0] ready;

  logic               write_en_q;
  logic [ADDR_W-1:0]  write_addr_q;
  logic [DATA_W-1:0]  write_data_q;
  logic [1:0]         grant_id_q;

  // Rotating priority in two passes: the lowest valid index at or above ptr
  // wins; otherwise the search has wrapped and the lowest valid index wins.
  // Scanning downwards means the last hit seen is the lowest index.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_bus.req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = 2'(i);
        if (2'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = 2'(i);
        end
      end
    end
    grant_valid = (hi_found | lo_found) & ~rst & ~flush;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  assign grant_addr = req_bus.req_addr[int'(grant_idx)*int'(ADDR_W) +: ADDR_W];
  assign grant_data = req_bus.req_data[int'(grant_idx)*int'(DATA_W) +: DATA_W];
  // x0 is hardwired: the grant still consumes the request, but nothing is written.
  assign do_write   = grant_valid & (grant_addr != '0);

  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
    end
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      ready[i] = grant_valid & (grant_idx == 2'(i));
    end
  end

  assign req_bus.req_ready = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      grant_id_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      write_en_q <= do_write;
      // Address/data/id only change when a real write lands; otherwise hold.
      if (do_write) begin
        write_addr_q <= grant_addr;
        write_data_q <= grant_data;
        grant_id_q   <= grant_idx;
      end
    end
  end

  assign WriteEn   = write_en_q;
  assign WriteAddr = write_addr_q;
  assign WriteData = write_data_q;
  assign grant_id  = grant_id_q;

`ifdef WB_FWD_EN
  assign fwd_hit1 = write_en_q & (write_addr_q == fwd_addr1) & (fwd_addr1 != '0);
  assign fwd_hit2 = write_en_q & (write_addr_q == fwd_addr2) & (fwd_addr2 != '0);
  assign fwd_data = write_data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [1:0]    gid;
`ifdef WB_FWD_EN
  logic [AW-1:0] fwd_addr1, fwd_addr2;
  logic          fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data;
`endif

  int n_checks;
  int n_fail;

  regfile_wb_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_bus   (bus),
`ifdef WB_FWD_EN
    .fwd_addr1 (fwd_addr1),
    .fwd_addr2 (fwd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data  (fwd_data),
`endif
    .WriteEn   (we),
    .WriteAddr (waddr),
    .WriteData (wdata),
    .grant_id  (gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req_valid[i]         = v;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 1), DW'(i + 1));
    cyc();
    cyc();
    n_checks++;
    if (bus.req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ready_forced: got %b want 000", bus.req_ready);
    end
    n_checks++;
    if ({we, waddr, wdata, gid} !== {1'b0, 5'd0, 32'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b a=%0d d=%h g=%0d", we, waddr, wdata, gid);
    end
    rst = 1'b0;
    clear_reqs();
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_ready[%0d]: got %b want 000", k, bus.req_ready);
      end
      cyc();
      n_checks++;
      if ({we, waddr, wdata, gid} !== {1'b0, 5'd0, 32'd0, 2'd0}) begin
        n_fail++;
        $display("FAIL idle_outputs[%0d]: got we=%b a=%0d d=%h g=%0d", k, we, waddr, wdata,
                 gid);
      end
    end
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 5'd5, 32'h5);
    #1;
    n_checks++;
    if (bus.req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 001", bus.req_ready);
    end
    cyc();
    n_checks++;
    if ({we, waddr, wdata, gid} !== {1'b1, 5'd5, 32'h5, 2'd0}) begin
      n_fail++;
      $display("FAIL single_write: got we=%b a=%0d d=%h g=%0d want 1/5/5/0", we, waddr, wdata,
               gid);
    end
`ifdef WB_FWD_EN
    fwd_addr1 = 5'd5;
    fwd_addr2 = 5'd6;
    #1;
    n_checks++;
    if ({fwd_hit1, fwd_hit2, fwd_data} !== {1'b1, 1'b0, 32'h5}) begin
      n_fail++;
      $display("FAIL fwd_lookup: got h1=%b h2=%b d=%h want 1/0/5", fwd_hit1, fwd_hit2,
               fwd_data);
    end
`endif
    clear_reqs();
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'hA + i));
    #1;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (bus.req_ready !== 3'(1 << (k % 3))) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: got %b want %b", k, bus.req_ready, 3'(1 << (k % 3)));
      end
      cyc();
      n_checks++;
      if ({we, waddr, wdata, gid} !== {1'b1, 5'(k % 3 + 1), 32'(10 + k % 3), 2'(k % 3)}) begin
        n_fail++;
        $display("FAIL rr_write[%0d]: got we=%b a=%0d d=%h g=%0d", k, we, waddr, wdata, gid);
      end
    end
    clear_reqs();
    cyc();
    n_checks++;
    if ({we, waddr, wdata, gid} !== {1'b0, 5'd3, 32'hC, 2'd2}) begin
      n_fail++;
      $display("FAIL rr_idle_hold: got we=%b a=%0d d=%h g=%0d want 0/3/c/2", we, waddr, wdata,
               gid);
    end
  endtask

  task automatic test_addr_zero();
    set_req(1, 1'b1, 5'd0, 32'hDEAD);
    #1;
    n_checks++;
    if (bus.req_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL x0_ready: got %b want 010", bus.req_ready);
    end
    cyc();
    n_checks++;
    if (we !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_no_write: got we=%b want 0", we);
    end
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'h31 + i));
    #1;
    n_checks++;
    if (bus.req_ready !== 3'b100) begin
      n_fail++;
      $display("FAIL x0_ptr_advanced: got %b want 100", bus.req_ready);
    end
    cyc();
    n_checks++;
    if ({we, waddr, wdata, gid} !== {1'b1, 5'd3, 32'h33, 2'd2}) begin
      n_fail++;
      $display("FAIL x0_next_write: got we=%b a=%0d d=%h g=%0d", we, waddr, wdata, gid);
    end
    clear_reqs();
  endtask

  task automatic test_collision();
    set_req(0, 1'b1, 5'd7, 32'h11);
    set_req(2, 1'b1, 5'd7, 32'h22);
    #1;
    n_checks++;
    if (bus.req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL coll_ready0: got %b want 001", bus.req_ready);
    end
    cyc();
    n_checks++;
    if ({we, waddr, wdata, gid} !== {1'b1, 5'd7, 32'h11, 2'd0}) begin
      n_fail++;
      $display("FAIL coll_write0: got we=%b a=%0d d=%h g=%0d", we, waddr, wdata, gid);
    end
    set_req(0, 1'b0, '0, '0);
    #1;
    n_checks++;
    if (bus.req_ready !== 3'b100) begin
      n_fail++;
      $display("FAIL coll_ready2: got %b want 100", bus.req_ready);
    end
    cyc();
    n_checks++;
    if ({we, waddr, wdata, gid} !== {1'b1, 5'd7, 32'h22, 2'd2}) begin
      n_fail++;
      $display("FAIL coll_write2: got we=%b a=%0d d=%h g=%0d", we, waddr, wdata, gid);
    end
    clear_reqs();
    cyc();
    n_checks++;
    if ({we, waddr, wdata} !== {1'b0, 5'd7, 32'h22}) begin
      n_fail++;
      $display("FAIL coll_final: got we=%b a=%0d d=%h want 0/7/22", we, waddr, wdata);
    end
  endtask

  task automatic test_flush();
    set_req(1, 1'b1, 5'd9, 32'h99);
    flush = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== 3'b000) begin
        n_fail++;
        $display("FAIL flush_ready[%0d]: got %b want 000", k, bus.req_ready);
      end
      cyc();
      n_checks++;
      if (we !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_write[%0d]: got we=%b want 0", k, we);
      end
    end
    flush = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL flush_release_ready: got %b want 010", bus.req_ready);
    end
    cyc();
    n_checks++;
    if ({we, waddr, wdata, gid} !== {1'b1, 5'd9, 32'h99, 2'd1}) begin
      n_fail++;
      $display("FAIL flush_release_write: got we=%b a=%0d d=%h g=%0d", we, waddr, wdata, gid);
    end
    // Flush arriving while a write is already registered.
    set_req(1, 1'b0, '0, '0);
    set_req(2, 1'b1, 5'd10, 32'hAA);
    flush = 1'b1;
    #1;
    n_checks++;
    if ({we, bus.req_ready} !== {1'b1, 3'b000}) begin
      n_fail++;
      $display("FAIL flush_inflight: got we=%b ready=%b want 1/000", we, bus.req_ready);
    end
    cyc();
    n_checks++;
    if (we !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after_inflight: got we=%b want 0", we);
    end
    flush = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 3'b100) begin
      n_fail++;
      $display("FAIL flush_ptr_held: got %b want 100", bus.req_ready);
    end
    cyc();
    n_checks++;
    if ({we, waddr, wdata, gid} !== {1'b1, 5'd10, 32'hAA, 2'd2}) begin
      n_fail++;
      $display("FAIL flush_req2_write: got we=%b a=%0d d=%h g=%0d", we, waddr, wdata, gid);
    end
    clear_reqs();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'h100 + i));
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== 3'(1 << k)) begin
        n_fail++;
        $display("FAIL mid_ready[%0d]: got %b want %b", k, bus.req_ready, 3'(1 << k));
      end
      cyc();
      n_checks++;
      if ({we, waddr, wdata, gid} !== {1'b1, 5'(k + 1), 32'(32'h100 + k), 2'(k)}) begin
        n_fail++;
        $display("FAIL mid_write[%0d]: got we=%b a=%0d d=%h g=%0d", k, we, waddr, wdata, gid);
      end
    end
    rst   = 1'b1;
    flush = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_rst_ready: got %b want 000", bus.req_ready);
    end
    cyc();
    n_checks++;
    if ({we, waddr, wdata, gid} !== {1'b0, 5'd0, 32'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL mid_rst_outputs: got we=%b a=%0d d=%h g=%0d", we, waddr, wdata, gid);
    end
    rst   = 1'b0;
    flush = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_rst_ptr: got %b want 001", bus.req_ready);
    end
    cyc();
    n_checks++;
    if ({we, waddr, wdata, gid} !== {1'b1, 5'd1, 32'h100, 2'd0}) begin
      n_fail++;
      $display("FAIL mid_rst_resume: got we=%b a=%0d d=%h g=%0d", we, waddr, wdata, gid);
    end
    clear_reqs();
    cyc();
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
`ifdef WB_FWD_EN
    fwd_addr1 = '0;
    fwd_addr2 = '0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_addr_zero();
    test_collision();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
